// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the mips pipeline memory arbiter
package mips_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} arb_state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port between fetch and data stages, data first with a starvation guard
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  arb_state_t state_q, state_d;
  logic owner_q, mem_we_q, idle, dm_gnt, if_gnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic [3:0] starve_q, starve_d;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Data wins unless fetch has waited through STARVE_MAX data grants.
  always_comb begin
    idle = state_q == IDLE;
    dm_gnt = idle & dm_req & ~(if_req & (starve_q == SMAX));
    if_gnt = idle & if_req & ~dm_gnt;
    state_d = idle ? (dm_gnt ? DM_BUSY : if_gnt ? IF_BUSY : IDLE)
            : state_q == RESP ? IDLE : mem_ack ? RESP : state_q;
    starve_d = (if_gnt | (idle & ~if_req)) ? 4'd0
             : (dm_gnt & if_req & (starve_q != SMAX)) ? starve_q + 4'd1 : starve_q;
  end
  always_comb begin
    mem_req = state_q == IF_BUSY || state_q == DM_BUSY;
    mem_we = mem_we_q;
    mem_addr = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata = if_rdata_q;
    dm_rdata = dm_rdata_q;
    if_ack = state_q == RESP && owner_q == OWN_IF;
    dm_ack = state_q == RESP && owner_q == OWN_DM;
    stall_if = if_req & ~if_ack;
    stall_mem = dm_req & ~dm_ack;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_IF;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q <= 4'd0;
    end else begin
      if (dm_gnt | if_gnt) begin
        owner_q <= dm_gnt ? OWN_DM : OWN_IF;
        mem_we_q <= dm_gnt & dm_we;
        mem_addr_q <= dm_gnt ? dm_addr : if_addr;
      end
      if (dm_gnt) mem_wdata_q <= dm_wdata;
      if (state_q == IF_BUSY && mem_ack) if_rdata_q <= mem_rdata;
      if (state_q == DM_BUSY && mem_ack && !mem_we_q) dm_rdata_q <= mem_rdata;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed checks of arbitration, timing, starvation and reset abort
module tb_mips_mem_arbiter;
  import mips_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ack, dm_ack, stall_if, stall_mem, mem_req, mem_we;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  mips_mem_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack), .stall_if(stall_if), .stall_mem(stall_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Called in the first mem_req cycle; mem_ack lands lat cycles into the request.
  task automatic serve(input int lat, input logic [31:0] d);
    for (int i = 1; i < lat; i++) tick();
    mem_ack = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if ({if_ack, dm_ack, stall_if, stall_mem, mem_we} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {if_ack, dm_ack, stall_if, stall_mem, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask
  task automatic test_fetch();
    if_req = 1'b1;
    if_addr = 32'h40;
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_issue got req=%b addr=%h we=%b want 1 00000040 0", mem_req, mem_addr, mem_we); end
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fetch_stall got %b want 1", stall_if); end
    serve(2, 32'h8C020004);
    n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h8C020004) begin n_bad++; $display("FAIL fetch_ack got ack=%b data=%h want 1 8c020004", if_ack, if_rdata); end
    n_cmp++; if (stall_if !== 1'b0 || mem_req !== 1'b0 || dm_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_resp got stall=%b req=%b dm_ack=%b want 0 0 0", stall_if, mem_req, dm_ack); end
    if_req = 1'b0;
    tick();
    n_cmp++; if (if_ack !== 1'b0 || dut.state_q !== IDLE) begin n_bad++; $display("FAIL fetch_pulse got ack=%b state=%0d want 0 IDLE", if_ack, dut.state_q); end
  endtask
  task automatic test_simultaneous();
    if_req = 1'b1;
    if_addr = 32'h44;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h100;
    tick();
    n_cmp++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_bad++; $display("FAIL sim_dm_first got addr=%h we=%b want 00000100 0", mem_addr, mem_we); end
    n_cmp++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin n_bad++; $display("FAIL sim_stalls got %b%b want 11", stall_if, stall_mem); end
    serve(1, 32'h11112222);
    n_cmp++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h11112222 || if_ack !== 1'b0) begin n_bad++; $display("FAIL sim_dm_ack got ack=%b data=%h if_ack=%b want 1 11112222 0", dm_ack, dm_rdata, if_ack); end
    n_cmp++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL sim_resp_stalls got %b%b want 10", stall_if, stall_mem); end
    dm_req = 1'b0;
    tick();
    n_cmp++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin n_bad++; $display("FAIL sim_idle got req=%b stall=%b want 0 1", mem_req, stall_if); end
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_bad++; $display("FAIL sim_if_grant got req=%b addr=%h want 1 00000044", mem_req, mem_addr); end
    serve(1, 32'h33334444);
    n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h33334444) begin n_bad++; $display("FAIL sim_if_ack got ack=%b data=%h want 1 33334444", if_ack, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask
  task automatic test_write();
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h200;
    dm_wdata = 32'hDEADBEEF;
    tick();
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_issue got we=%b addr=%h wdata=%h want 1 00000200 deadbeef", mem_we, mem_addr, mem_wdata); end
    dm_wdata = 32'h0;
    dm_addr = 32'h0;
    serve(1, 32'hCAFEF00D);
    n_cmp++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h11112222) begin n_bad++; $display("FAIL wr_ack got ack=%b rdata=%h want 1 11112222", dm_ack, dm_rdata); end
    dm_req = 1'b0;
    dm_we = 1'b0;
    tick();
  endtask
  task automatic test_back_to_back_starvation();
    int last;
    logic [31:0] want;
    if_req = 1'b1;
    if_addr = 32'h80;
    dm_req = 1'b1;
    dm_addr = 32'h300;
    last = -1;
    for (int g = 0; g < 5; g++) begin
      tick();
      want = (g < 4) ? 32'h300 : 32'h80;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== want) begin n_bad++; $display("FAIL starve_grant%0d got req=%b addr=%h want 1 %h", g, mem_req, mem_addr, want); end
      n_cmp++; if (dut.starve_q !== ((g < 4) ? 4'(g + 1) : 4'd0)) begin n_bad++; $display("FAIL starve_cnt%0d got %0d want %0d", g, dut.starve_q, (g < 4) ? g + 1 : 0); end
      if (last >= 0) begin
        n_cmp++; if (cyc - last !== 3) begin n_bad++; $display("FAIL b2b_spacing%0d got %0d want 3", g, cyc - last); end
      end
      last = cyc;
      serve(1, 32'hA0 + 32'(g));
      n_cmp++; if ({if_ack, dm_ack} !== ((g < 4) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL starve_ack%0d got %b want %b", g, {if_ack, dm_ack}, (g < 4) ? 2'b01 : 2'b10); end
      if (g == 4) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      tick();
    end
    n_cmp++; if (dut.starve_q !== 4'd0 || dut.state_q !== IDLE) begin n_bad++; $display("FAIL starve_end got cnt=%0d state=%0d want 0 IDLE", dut.starve_q, dut.state_q); end
  endtask
  task automatic test_reset_mid();
    dm_req = 1'b1;
    dm_addr = 32'h400;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", mem_req); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dm_req = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || dut.state_q !== IDLE) begin n_bad++; $display("FAIL rmid_abort got req=%b state=%0d want 0 IDLE", mem_req, dut.state_q); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h5555AAAA;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (dm_ack !== 1'b0 || if_ack !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_late_ack got dm_ack=%b if_ack=%b req=%b rdata=%h want 0 0 0 0", dm_ack, if_ack, mem_req, dm_rdata); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rmid_state got %0d want IDLE", dut.state_q); end
    if_req = 1'b1;
    if_addr = 32'h48;
    tick();
    n_cmp++; if (mem_addr !== 32'h48 || mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_next got addr=%h req=%b want 00000048 1", mem_addr, mem_req); end
    serve(2, 32'h12345678);
    n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rmid_next_ack got ack=%b data=%h want 1 12345678", if_ack, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask
  task automatic test_spurious_ack();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, mem_we, if_ack, dm_ack, stall_if, stall_mem} !== 6'b0) begin n_bad++; $display("FAIL spur_flags got %b want 000000", {mem_req, mem_we, if_ack, dm_ack, stall_if, stall_mem}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin n_bad++; $display("FAIL spur_data got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_back_to_back_starvation();
    test_reset_mid();
    test_spurious_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
